mc_sequencer: RTL and testbench

Instruction sequencer and accumulator stage that sits directly upstream of `alu`. It fetches one instruction per cycle from an external combinational program ROM and drives `alu` operands and `funct`. It writes the ALU result back into the accumulator, and captures compare flags into a Shenzhen-style +/− condition state. It implements conditional lines, once-only (`@`) lines and `slp`, and wraps around the program.

---
 rtl/mc_sequencer.sv | 156 +++++++++++++++
 tb/tb_mc_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_sequencer.sv
// Instruction sequencer and accumulator stage feeding the alu: one line per cycle,
// conditional (+/-) and once-only lines, sleep, and program wrap-around.
module mc_sequencer #(
    parameter int PROG_LEN = 8,
    parameter int PC_W     = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [23:0]     instr,
    input  logic [10:0]     alu_out,
    input  logic            alu_overflow,
    input  logic            alu_gr,
    input  logic            alu_le,
    input  logic            alu_eq,
    output logic [PC_W-1:0] pc,
    output logic [10:0]     alu_in0,
    output logic [10:0]     alu_in1,
    output logic [3:0]      alu_funct,
    output logic [10:0]     acc,
    output logic [1:0]      cond,
    output logic            sleeping,
    output logic            ovf,
    output logic            exec_valid
);

    typedef enum logic [1:0] {
        COND_NONE  = 2'b00,
        COND_PLUS  = 2'b01,
        COND_MINUS = 2'b10
    } cond_e;

    localparam logic [2:0] K_MOV = 3'd1;
    localparam logic [2:0] K_ALU = 3'd2;
    localparam logic [2:0] K_TEQ = 3'd3;
    localparam logic [2:0] K_TGT = 3'd4;
    localparam logic [2:0] K_TLT = 3'd5;
    localparam logic [2:0] K_SLP = 3'd6;

    logic [PC_W-1:0]        r_pc;
    logic [10:0]            r_acc;
    cond_e                  r_cond;
    logic [10:0]            r_sleep;
    logic                   r_ovf;
    logic                   r_exec_valid;
    // Sized to the full pc range so pc indexes it without width adaptation.
    logic [(2**PC_W)-1:0]   r_done;

    logic                   w_sleeping;
    logic                   w_gate;
    logic                   w_once_blk;
    logic                   w_exec;
    logic                   w_last;
    logic                   w_imm_pos;
    logic                   w_unused_rsvd;
    logic [PC_W-1:0]        w_pc_n;
    logic [10:0]            w_acc_n;
    cond_e                  w_cond_n;
    logic [10:0]            w_sleep_n;
    logic                   w_ovf_n;
    logic [(2**PC_W)-1:0]   w_done_n;

    assign w_sleeping    = (r_sleep != 11'd0);
    assign w_once_blk    = instr[21] & r_done[r_pc];
    assign w_exec        = ~w_sleeping & w_gate & ~w_once_blk;
    assign w_last        = (r_pc == PC_W'(PROG_LEN - 1));
    assign w_imm_pos     = ~instr[10] & (instr[10:0] != 11'd0);
    assign w_unused_rsvd = ^instr[13:11];

    // Condition gate: NONE satisfies neither + nor - lines.
    always_comb begin
        w_gate = 1'b0;
        case (instr[23:22])
            2'b00:   w_gate = 1'b1;
            2'b01:   w_gate = (r_cond == COND_PLUS);
            2'b10:   w_gate = (r_cond == COND_MINUS);
            default: w_gate = 1'b0;
        endcase
    end

    // Next-state computation for one program line.
    always_comb begin
        w_pc_n    = r_pc;
        w_acc_n   = r_acc;
        w_cond_n  = r_cond;
        w_sleep_n = r_sleep;
        w_ovf_n   = r_ovf;
        w_done_n  = r_done;
        if (w_sleeping) begin
            w_sleep_n = r_sleep - 11'd1;
        end else begin
            w_pc_n = w_last ? {PC_W{1'b0}} : r_pc + PC_W'(1);
            if (w_exec) begin
                case (instr[20:18])
                    K_MOV: w_acc_n = instr[10:0];
                    K_ALU: begin
                        w_acc_n = alu_out;
                        w_ovf_n = r_ovf | alu_overflow;
                    end
                    K_TEQ: w_cond_n = alu_eq ? COND_PLUS : COND_MINUS;
                    K_TGT: w_cond_n = alu_gr ? COND_PLUS : COND_MINUS;
                    K_TLT: w_cond_n = alu_le ? COND_PLUS : COND_MINUS;
                    K_SLP: begin
                        if (w_imm_pos) begin
                            w_sleep_n = instr[10:0] - 11'd1;
                        end else begin
                            w_sleep_n = r_sleep;
                        end
                    end
                    default: w_acc_n = r_acc;
                endcase
                if (instr[21]) begin
                    w_done_n[r_pc] = 1'b1;
                end else begin
                    w_done_n = r_done;
                end
            end else begin
                w_done_n = r_done;
            end
        end
    end

    // State registers; en=0 freezes everything and suppresses exec_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc         <= {PC_W{1'b0}};
            r_acc        <= 11'd0;
            r_cond       <= COND_NONE;
            r_sleep      <= 11'd0;
            r_ovf        <= 1'b0;
            r_exec_valid <= 1'b0;
            r_done       <= {(2**PC_W){1'b0}};
        end else if (en) begin
            r_pc         <= w_pc_n;
            r_acc        <= w_acc_n;
            r_cond       <= w_cond_n;
            r_sleep      <= w_sleep_n;
            r_ovf        <= w_ovf_n;
            r_exec_valid <= w_exec;
            r_done       <= w_done_n;
        end else begin
            r_exec_valid <= 1'b0;
        end
    end

    assign pc         = r_pc;
    assign acc        = r_acc;
    assign alu_in0    = r_acc;
    assign alu_in1    = instr[10:0];
    assign alu_funct  = instr[17:14];
    assign cond       = r_cond;
    assign sleeping   = w_sleeping;
    assign ovf        = r_ovf;
    assign exec_valid = r_exec_valid;

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: an 8-line and a 4-line instance run side by side against a
// line-level program model, with an external alu model and hand-computed pins.
module tb_mc_sequencer;

    localparam logic [1:0] AL = 2'b00;
    localparam logic [1:0] PL = 2'b01;
    localparam logic [1:0] MI = 2'b10;
    localparam logic [1:0] NV = 2'b11;
    localparam logic [2:0] NOP = 3'd0;
    localparam logic [2:0] MOV = 3'd1;
    localparam logic [2:0] ALU = 3'd2;
    localparam logic [2:0] TEQ = 3'd3;
    localparam logic [2:0] TGT = 3'd4;
    localparam logic [2:0] SLP = 3'd6;
    localparam logic [3:0] F_ADD = 4'd0;
    localparam logic [3:0] F_MUL = 4'd1;

    logic clk, reset, en;
    logic [23:0] rom8 [0:15];
    logic [23:0] rom4 [0:3];

    logic [3:0]  pc8;
    logic [1:0]  pc4;
    logic [23:0] instr8, instr4;
    logic [10:0] in0_8, in1_8, acc8, out8, in0_4, in1_4, acc4, out4;
    logic [3:0]  fn8, fn4;
    logic [1:0]  cond8, cond4;
    logic sl8, ov8, ev8, aov8, gr8, le8, eq8;
    logic sl4, ov4, ev4, aov4, gr4, le4, eq4;

    int n_vec = 0;
    int n_err = 0;

    int m_pc [2];
    int m_acc [2];
    int m_cond [2];
    int m_sleep [2];
    int m_ovf [2];
    int m_ev [2];
    logic [15:0] m_done [2];

    // External alu: 0 add, 1 multiply, others subtract; flags compare in0 against in1.
    function automatic logic [14:0] alu_f(input logic [10:0] a, input logic [10:0] b, input logic [3:0] f);
        int sa, sb, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (f)
            4'd0:    r = sa + sb;
            4'd1:    r = sa * sb;
            default: r = sa - sb;
        endcase
        return {(r > 1023 || r < -1024), sa > sb, sa < sb, sa == sb, r[10:0]};
    endfunction

    function automatic logic [23:0] ins(input logic [1:0] c, input logic o, input logic [2:0] k,
                                        input logic [3:0] f, input int imm);
        logic [10:0] i11;
        i11 = imm[10:0];
        return {c, o, k, f, 3'b000, i11};
    endfunction

    function automatic int sx11(input int v);
        logic signed [10:0] t;
        t = v[10:0];
        return int'(t);
    endfunction

    assign instr8 = rom8[pc8];
    assign instr4 = rom4[pc4];
    assign {aov8, gr8, le8, eq8, out8} = alu_f(in0_8, in1_8, fn8);
    assign {aov4, gr4, le4, eq4, out4} = alu_f(in0_4, in1_4, fn4);

    mc_sequencer #(.PROG_LEN(8), .PC_W(4)) u_dut8 (
        .clk(clk), .reset(reset), .en(en), .instr(instr8), .alu_out(out8),
        .alu_overflow(aov8), .alu_gr(gr8), .alu_le(le8), .alu_eq(eq8),
        .pc(pc8), .alu_in0(in0_8), .alu_in1(in1_8), .alu_funct(fn8), .acc(acc8),
        .cond(cond8), .sleeping(sl8), .ovf(ov8), .exec_valid(ev8)
    );

    mc_sequencer #(.PROG_LEN(4), .PC_W(2)) u_dut4 (
        .clk(clk), .reset(reset), .en(en), .instr(instr4), .alu_out(out4),
        .alu_overflow(aov4), .alu_gr(gr4), .alu_le(le4), .alu_eq(eq4),
        .pc(pc4), .alu_in0(in0_4), .alu_in1(in1_4), .alu_funct(fn4), .acc(acc4),
        .cond(cond4), .sleeping(sl4), .ovf(ov4), .exec_valid(ev4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 0; m_acc[k] = 0; m_cond[k] = 0; m_sleep[k] = 0;
            m_ovf[k] = 0; m_ev[k] = 0; m_done[k] = 16'h0000;
        end
    endtask

    // One enabled edge of program k: a whole line, or one sleep tick.
    task automatic step(input int k);
        logic [23:0] w;
        logic signed [10:0] im;
        int imm, r, plen;
        bit ok;
        plen = (k == 0) ? 8 : 4;
        if (!en) begin
            m_ev[k] = 0;
            return;
        end
        if (m_sleep[k] > 0) begin
            m_sleep[k] = m_sleep[k] - 1;
            m_ev[k] = 0;
            return;
        end
        w = (k == 0) ? rom8[m_pc[k]] : rom4[m_pc[k]];
        im = w[10:0];
        imm = int'(im);
        case (w[23:22])
            2'b00:   ok = 1'b1;
            2'b01:   ok = (m_cond[k] == 1);
            2'b10:   ok = (m_cond[k] == 2);
            default: ok = 1'b0;
        endcase
        if (w[21] && m_done[k][m_pc[k]]) ok = 1'b0;
        if (ok) begin
            case (int'(w[20:18]))
                1: m_acc[k] = imm;
                2: begin
                    if (w[17:14] == 4'd0) r = m_acc[k] + imm;
                    else if (w[17:14] == 4'd1) r = m_acc[k] * imm;
                    else r = m_acc[k] - imm;
                    if (r > 1023 || r < -1024) m_ovf[k] = 1;
                    m_acc[k] = sx11(r);
                end
                3: m_cond[k] = (m_acc[k] == imm) ? 1 : 2;
                4: m_cond[k] = (m_acc[k] > imm) ? 1 : 2;
                5: m_cond[k] = (m_acc[k] < imm) ? 1 : 2;
                6: if (imm > 0) m_sleep[k] = imm - 1;
                default: ;
            endcase
            if (w[21]) m_done[k][m_pc[k]] = 1'b1;
        end
        m_ev[k] = ok ? 1 : 0;
        m_pc[k] = (m_pc[k] + 1) % plen;
    endtask

    task automatic check_all();
        int a_pc, a_acc, a_cond, a_sl, a_ov, a_ev, a_i0, a_i1, a_f;
        logic [23:0] w;
        string pf;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                pf = "d8";
                a_pc = int'(pc8); a_acc = int'($signed(acc8)); a_cond = int'(cond8);
                a_sl = int'(sl8); a_ov = int'(ov8); a_ev = int'(ev8);
                a_i0 = int'($signed(in0_8)); a_i1 = int'(in1_8); a_f = int'(fn8);
                w = rom8[m_pc[0]];
            end else begin
                pf = "d4";
                a_pc = int'(pc4); a_acc = int'($signed(acc4)); a_cond = int'(cond4);
                a_sl = int'(sl4); a_ov = int'(ov4); a_ev = int'(ev4);
                a_i0 = int'($signed(in0_4)); a_i1 = int'(in1_4); a_f = int'(fn4);
                w = rom4[m_pc[1]];
            end
            chk({pf, "_pc"}, a_pc, m_pc[k]);
            chk({pf, "_acc"}, a_acc, m_acc[k]);
            chk({pf, "_cond"}, a_cond, m_cond[k]);
            chk({pf, "_sleeping"}, a_sl, (m_sleep[k] > 0) ? 1 : 0);
            chk({pf, "_ovf"}, a_ov, m_ovf[k]);
            chk({pf, "_exec_valid"}, a_ev, m_ev[k]);
            chk({pf, "_alu_in0"}, a_i0, m_acc[k]);
            chk({pf, "_alu_in1"}, a_i1, int'(w[10:0]));
            chk({pf, "_alu_funct"}, a_f, int'(w[17:14]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (reset) begin
            model_reset();
        end else begin
            step(0);
            step(1);
        end
        check_all();
    endtask

    task automatic clear_roms();
        for (int i = 0; i < 16; i++) rom8[i] = ins(NV, 1'b0, NOP, F_ADD, 0);
        for (int i = 0; i < 4; i++) rom4[i] = ins(NV, 1'b0, NOP, F_ADD, 0);
    endtask

    task automatic set_line(input int i, input logic [23:0] w);
        rom8[i] = w;
        if (i < 4) rom4[i] = w;
    endtask

    task automatic start();
        reset = 1'b1;
        en = 1'b1;
        #1;
        model_reset();
        check_all();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        en = 1'b1;
        clear_roms();

        // Arithmetic: 200, 204, 816 and exactly three executed lines.
        clear_roms();
        set_line(0, ins(AL, 1'b0, MOV, F_ADD, 200));
        set_line(1, ins(AL, 1'b0, ALU, F_ADD, 4));
        set_line(2, ins(AL, 1'b0, ALU, F_MUL, 4));
        start();
        chk("lit_reset_pc", int'(pc8), 0);
        tick(); chk("lit_acc_200", int'($signed(acc8)), 200); chk("lit_ev1", int'(ev8), 1);
        tick(); chk("lit_acc_204", int'($signed(acc8)), 204); chk("lit_ev2", int'(ev8), 1);
        tick(); chk("lit_acc_816", int'($signed(acc8)), 816); chk("lit_ev3", int'(ev8), 1);
        tick(); chk("lit_ev4", int'(ev8), 0); chk("lit_ovf0", int'(ov8), 0);
        for (int i = 0; i < 6; i++) tick();

        // Conditions: line 3 skipped, acc ends 3, cond ends MINUS.
        clear_roms();
        set_line(0, ins(AL, 1'b0, MOV, F_ADD, 5));
        set_line(1, ins(AL, 1'b0, TEQ, F_MUL, 5));
        set_line(2, ins(PL, 1'b0, MOV, F_ADD, 1));
        set_line(3, ins(MI, 1'b0, MOV, F_ADD, 2));
        set_line(4, ins(AL, 1'b0, TGT, F_ADD, 9));
        set_line(5, ins(MI, 1'b0, MOV, F_ADD, 3));
        start();
        tick(); tick(); chk("lit_cond_plus", int'(cond8), 1);
        tick(); chk("lit_acc_1", int'($signed(acc8)), 1);
        tick(); chk("lit_skip_ev", int'(ev8), 0);
        tick(); tick();
        chk("lit_acc_3", int'($signed(acc8)), 3);
        chk("lit_cond_minus", int'(cond8), 2);
        for (int i = 0; i < 4; i++) tick();

        // A + line straight after reset sees NONE and is skipped.
        clear_roms();
        set_line(0, ins(PL, 1'b0, MOV, F_ADD, 7));
        start();
        tick();
        chk("lit_plus_none_acc", int'($signed(acc8)), 0);
        chk("lit_plus_none_ev", int'(ev8), 0);
        tick(); tick();

        // Once line and wrap on the 4-line program: 3 loops end at acc=13.
        clear_roms();
        set_line(0, ins(AL, 1'b1, MOV, F_ADD, 10));
        set_line(1, ins(AL, 1'b0, ALU, F_ADD, 1));
        set_line(2, ins(AL, 1'b0, NOP, F_ADD, 0));
        set_line(3, ins(AL, 1'b0, NOP, F_ADD, 0));
        start();
        for (int i = 0; i < 4; i++) tick();
        chk("lit_wrap_pc", int'(pc4), 0);
        tick(); chk("lit_once_skip", int'(ev4), 0);
        for (int i = 0; i < 7; i++) tick();
        chk("lit_once_acc_13", int'($signed(acc4)), 13);

        // Sleep: SLP 3 holds for two sleeping cycles; SLP 0 and SLP -5 take one cycle.
        clear_roms();
        set_line(0, ins(AL, 1'b0, SLP, F_ADD, 3));
        set_line(1, ins(AL, 1'b0, MOV, F_ADD, 1));
        set_line(2, ins(AL, 1'b0, SLP, F_ADD, 0));
        set_line(3, ins(AL, 1'b0, MOV, F_ADD, 2));
        set_line(4, ins(AL, 1'b0, SLP, F_ADD, -5));
        set_line(5, ins(AL, 1'b0, MOV, F_ADD, 3));
        start();
        tick(); chk("lit_sleep_e1", int'(sl8), 1);
        tick(); chk("lit_sleep_e2", int'(sl8), 1); chk("lit_sleep_pc", int'(pc8), 1);
        tick(); chk("lit_sleep_e3", int'(sl8), 0); chk("lit_sleep_acc0", int'($signed(acc8)), 0);
        tick(); chk("lit_mov_e4", int'($signed(acc8)), 1);
        tick(); tick(); chk("lit_slp0", int'($signed(acc8)), 2);
        tick(); tick(); chk("lit_slpneg", int'($signed(acc8)), 3);
        tick(); tick();

        // Overflow is sticky; en=0 freezes; reset mid-sleep clears at once.
        clear_roms();
        set_line(0, ins(AL, 1'b0, MOV, F_ADD, 999));
        set_line(1, ins(AL, 1'b0, ALU, F_MUL, 999));
        set_line(2, ins(AL, 1'b0, SLP, F_ADD, 5));
        set_line(3, ins(AL, 1'b0, MOV, F_ADD, 1));
        start();
        tick(); tick(); chk("lit_ovf_set", int'(ov8), 1);
        tick(); tick();
        en = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("lit_stall_sleep", int'(sl8), 1);
        chk("lit_stall_ev", int'(ev8), 0);
        chk("lit_ovf_sticky", int'(ov8), 1);
        en = 1'b1;
        tick();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("lit_rst_sleep", int'(sl8), 0);
        chk("lit_rst_ovf", int'(ov8), 0);
        tick();
        reset = 1'b0;
        tick(); chk("lit_resume_acc", int'($signed(acc8)), 999);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
